// File: rtl/sift_top_core_if.sv
// Result bundle of the feature-extraction core: two sticky completion flags
// and the descriptor byte stream.
interface sift_top_core_if;
  logic       complete1;
  logic       complete3;
  logic [7:0] desc_out;

  modport master (output complete1, output complete3, output desc_out);
  modport slave  (input  complete1, input  complete3, input  desc_out);
endinterface

// File: rtl/sift_top_core.sv
// SIFT-style core: scans a synthetic image, buffers 3x3 local-maximum
// keypoints, then streams a header plus 8-byte descriptors once per reset.
module sift_top_core #(
  parameter int         IMG_W  = 16,
  parameter int         IMG_H  = 16,
  parameter int         MAX_KP = 32,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic            clk_sys,
  input  logic            rst_sys,
  sift_top_core_if.master sift_if
);

  localparam int         CW    = $clog2(MAX_KP + 1);
  localparam int         IW    = $clog2(MAX_KP);
  localparam logic [7:0] X_LST = 8'(IMG_W - 1);
  localparam logic [7:0] Y_LST = 8'(IMG_H - 1);
  localparam logic [CW-1:0] KP_FULL = CW'(MAX_KP);

  typedef enum logic [1:0] {SCAN, HDR, EMIT, DONE} state_t;

  state_t state_q, state_d;
  logic [7:0]    x_q, x_d, y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d, rd_q, rd_d;
  logic [2:0]    byte_q, byte_d;
  logic [7:0]    desc_q, desc_d;
  logic          c1_q, c1_d, c3_q, c3_d;
  logic          kp_we;
  logic [7:0]    kp_x_q [MAX_KP];
  logic [7:0]    kp_y_q [MAX_KP];

  function automatic logic [7:0] pix(input logic [7:0] px, input logic [7:0] py);
    return (px[1:0] == 2'd2 && py[1:0] == 2'd2) ? 8'hF0 : px + py;
  endfunction

  logic       scan_last, interior, is_max;
  logic [7:0] pc;
  assign scan_last = (x_q == X_LST) && (y_q == Y_LST);
  assign interior  = (x_q != 8'd0) && (x_q != X_LST) && (y_q != 8'd0) && (y_q != Y_LST);
  assign pc        = pix(x_q, y_q);
  assign is_max    = (pc > pix(x_q - 8'd1, y_q - 8'd1)) && (pc > pix(x_q, y_q - 8'd1)) &&
                     (pc > pix(x_q + 8'd1, y_q - 8'd1)) && (pc > pix(x_q - 8'd1, y_q)) &&
                     (pc > pix(x_q + 8'd1, y_q))        && (pc > pix(x_q - 8'd1, y_q + 8'd1)) &&
                     (pc > pix(x_q, y_q + 8'd1))        && (pc > pix(x_q + 8'd1, y_q + 8'd1));

  // Descriptor fields are recomputed from the stored coordinates while emitting.
  logic [IW-1:0] rd_idx;
  logic [7:0]    kx, ky, kc, d_xp, d_xm, d_yp, d_ym, d_chk, desc_byte;
  assign rd_idx = (rd_q < KP_FULL) ? rd_q[IW-1:0] : '0;
  assign kx     = kp_x_q[rd_idx];
  assign ky     = kp_y_q[rd_idx];
  assign kc     = pix(kx, ky);
  assign d_xp   = kc - pix(kx + 8'd1, ky);
  assign d_xm   = kc - pix(kx - 8'd1, ky);
  assign d_yp   = kc - pix(kx, ky + 8'd1);
  assign d_ym   = kc - pix(kx, ky - 8'd1);
  assign d_chk  = kx ^ ky ^ d_xp ^ d_xm ^ d_yp ^ d_ym ^ kc;

  always_comb begin
    case (byte_q)
      3'd0:    desc_byte = kx;
      3'd1:    desc_byte = ky;
      3'd2:    desc_byte = d_xp;
      3'd3:    desc_byte = d_xm;
      3'd4:    desc_byte = d_yp;
      3'd5:    desc_byte = d_ym;
      3'd6:    desc_byte = kc;
      default: desc_byte = d_chk;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) state_q <= SCAN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    if (scan_last) state_d = HDR;
      HDR:     state_d = EMIT;
      EMIT:    if (rd_q == cnt_q) state_d = DONE;
      default: state_d = DONE;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    byte_d = byte_q;
    desc_d = 8'h00;
    c1_d   = c1_q;
    c3_d   = c3_q;
    kp_we  = 1'b0;
    case (state_q)
      SCAN: begin
        if (interior && is_max && cnt_q != KP_FULL) begin
          kp_we = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
        if (scan_last) begin
          c1_d = 1'b1;
        end else if (x_q == X_LST) begin
          x_d = 8'd0;
          y_d = y_q + 8'd1;
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      HDR: desc_d = HEADER;
      EMIT: begin
        if (rd_q == cnt_q) begin
          c3_d = 1'b1;
        end else begin
          desc_d = desc_byte;
          byte_d = byte_q + 3'd1;
          if (byte_q == 3'd7) rd_d = rd_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      x_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
      byte_q <= '0;
      desc_q <= '0;
      c1_q   <= 1'b0;
      c3_q   <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      byte_q <= byte_d;
      desc_q <= desc_d;
      c1_q   <= c1_d;
      c3_q   <= c3_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (kp_we) begin
      kp_x_q[cnt_q[IW-1:0]] <= x_q;
      kp_y_q[cnt_q[IW-1:0]] <= y_q;
    end
  end

  assign sift_if.complete1 = c1_q;
  assign sift_if.complete3 = c3_q;
  assign sift_if.desc_out  = desc_q;

endmodule

// File: tb/tb_sift_top_core.sv
// Cycle-accurate check of three core configurations against a stream model
// built directly from the image and keypoint rules.
module tb_sift_top_core;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sift_top_core_if if_a ();
  sift_top_core_if if_b ();
  sift_top_core_if if_c ();

  sift_top_core dut_a (.clk_sys(clk), .rst_sys(rst), .sift_if(if_a));
  sift_top_core #(.MAX_KP(8)) dut_b (.clk_sys(clk), .rst_sys(rst), .sift_if(if_b));
  sift_top_core #(.IMG_W(3), .IMG_H(3)) dut_c (.clk_sys(clk), .rst_sys(rst), .sift_if(if_c));

  bq_t str_a, str_b, str_c;

  function automatic int pm(int x, int y);
    if (x % 4 == 2 && y % 4 == 2) return 240;
    return (x + y) % 256;
  endfunction

  function automatic bq_t build(int w, int h, int mk);
    bq_t q;
    int  k = 0;
    q.push_back(8'hA5);
    for (int y = 1; y <= h - 2; y++)
      for (int x = 1; x <= w - 2; x++) begin
        int c = pm(x, y);
        bit mx = 1;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dx != 0 || dy != 0) && pm(x + dx, y + dy) >= c) mx = 0;
        if (mx && k < mk) begin
          logic [7:0] b [7];
          logic [7:0] chk = 8'h00;
          b[0] = 8'(x);
          b[1] = 8'(y);
          b[2] = 8'((c - pm(x + 1, y)) & 255);
          b[3] = 8'((c - pm(x - 1, y)) & 255);
          b[4] = 8'((c - pm(x, y + 1)) & 255);
          b[5] = 8'((c - pm(x, y - 1)) & 255);
          b[6] = 8'(c);
          for (int i = 0; i < 7; i++) begin
            q.push_back(b[i]);
            chk ^= b[i];
          end
          q.push_back(chk);
          k++;
        end
      end
    return q;
  endfunction

  task automatic chk(string tag, int n, logic [7:0] obs, logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s edge %0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  task automatic chk_cfg(string tag, int n, int npix, bq_t q,
                         logic c1, logic c3, logic [7:0] d);
    logic [7:0] ed;
    ed = (n >= npix && n - npix < q.size()) ? q[n - npix] : 8'h00;
    chk({tag, ".complete1"}, n, {7'd0, c1}, {7'd0, n >= npix - 1});
    chk({tag, ".complete3"}, n, {7'd0, c3}, {7'd0, n >= npix + q.size()});
    chk({tag, ".desc_out"},  n, d, ed);
  endtask

  task automatic run_seq(int upto);
    for (int n = 0; n <= upto; n++) begin
      @(posedge clk);
      #1;
      chk_cfg("dflt", n, 256, str_a, if_a.complete1, if_a.complete3, if_a.desc_out);
      chk_cfg("kp8",  n, 256, str_b, if_b.complete1, if_b.complete3, if_b.desc_out);
      chk_cfg("3x3",  n, 9,   str_c, if_c.complete1, if_c.complete3, if_c.desc_out);
    end
  endtask

  task automatic check_idle(string tag);
    chk({tag, ".a"}, -1, {if_a.complete1, if_a.complete3, if_a.desc_out[5:0]}, 8'h00);
    chk({tag, ".a.desc"}, -1, if_a.desc_out, 8'h00);
    chk({tag, ".b"}, -1, {if_b.complete1, if_b.complete3, if_b.desc_out[5:0]}, 8'h00);
    chk({tag, ".b.desc"}, -1, if_b.desc_out, 8'h00);
    chk({tag, ".c"}, -1, {if_c.complete1, if_c.complete3, if_c.desc_out[5:0]}, 8'h00);
    chk({tag, ".c.desc"}, -1, if_c.desc_out, 8'h00);
  endtask

  task automatic do_reset(int cyc);
    rst = 1'b1;
    #1;
    check_idle("rst");
    repeat (cyc) @(posedge clk);
    check_idle("rst_hold");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int r;
    str_a = build(16, 16, 32);
    str_b = build(16, 16, 8);
    str_c = build(3, 3, 32);

    #100;
    check_idle("por");
    @(negedge clk);
    rst = 1'b0;
    run_seq(395);

    do_reset($urandom_range(1, 6));
    run_seq(300);
    do_reset($urandom_range(1, 6));
    run_seq(395);

    for (int k = 0; k < 2; k++) begin
      r = $urandom_range(0, 390);
      do_reset($urandom_range(1, 6));
      run_seq(r);
    end
    do_reset($urandom_range(1, 6));
    run_seq(395);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sift_top_core.md
# sift_top_core

Self-contained feature-extraction pipeline: an internal synthetic 8-bit image is raster-scanned, local-maximum keypoints are detected in a 3×3 window (stage 1), buffered (stage 2), and emitted as fixed 8-byte descriptors on a byte stream (stage 3). It serves as the top-level SIFT-style processing core. It has no data inputs; it runs once per reset release and exposes two completion flags plus the descriptor byte stream.

## Interface
- IMG_W, 16, image width in pixels (3..255)
- IMG_H, 16, image height in pixels (3..255)
- MAX_KP, 32, keypoint buffer depth
- HEADER, 8'hA5, stream start byte
- clk_sys  input  1  single system clock, rising edge
- rst_sys  input  1  reset, asynchronous, active-high
- complete1  output  1  sticky: detection scan finished
- complete3  output  1  sticky: descriptor emission finished
- desc_out  output  8  descriptor byte stream, 0 when idle

## Operation
- Image (combinational function, 8-bit): P(x,y) = 8'hF0 if x%4==2 and y%4==2, else (x+y) truncated to 8 bits.
- Stage 1 scan: index i = y*IMG_W+x, raster order, one pixel per clock, i = 0..IMG_W*IMG_H-1.
- Keypoint: interior pixel (1≤x≤IMG_W-2, 1≤y≤IMG_H-2) with P(x,y) strictly greater than all 8 neighbours; border pixels never qualify; ties never qualify.
- Stage 2: each keypoint stores (x,y) into a buffer in detection order; when MAX_KP entries are held, further keypoints are dropped silently.
- Stage 3, per stored keypoint, 8 bytes in order: x, y, P(c)-P(x+1,y), P(c)-P(x-1,y), P(c)-P(x,y+1), P(c)-P(x,y-1), P(c), XOR of the previous 7 bytes. Subtractions are 8-bit modulo 256.
- Stream: HEADER, then all descriptors back to back in buffer order; nothing else. desc_out = 8'h00 outside these cycles.
- Zero keypoints: stream is HEADER only.
- States: SCAN -> HDR -> EMIT -> DONE. DONE holds until reset; no restart without reset.

## Timing
- Reset (async assert): scan index, buffer count, state, complete1, complete3 and desc_out all 0; state = SCAN.
- Edge n (n = 0 is the first rising edge with rst_sys low) processes scan index n.
- complete1 rises on the edge processing the last index (N-1, N = IMG_W*IMG_H) and stays high.
- Edge N: desc_out = HEADER.
- Edges N+1 .. N+8K: descriptor bytes, one per edge, K = stored keypoint count.
- Edge N+1+8K: desc_out = 0 and complete3 = 1, both held until reset.
- Defaults (K = 16): complete1 at edge 255, header at 256, bytes at 257..384, complete3 at 385.
- Reset mid-operation: every output clears immediately; after release the whole sequence restarts from index 0.

## Test plan
- Default run: hold reset 100 ns, release -> complete1 at edge 255, desc_out = 8'hA5 at edge 256, complete3 at edge 385, exactly 128 descriptor bytes.
- First descriptor, keypoint (2,2): 02 02 EB ED EB ED F0 F0.
- Last descriptor, keypoint (14,14): 0E 0E D3 D5 D3 D5 F0 F0; keypoints appear in order (2,2),(6,2),(10,2),(14,2),(2,6)…; every byte 7 = F0.
- MAX_KP=8 -> first 8 keypoints only (through y=6), complete3 at edge 321.
- IMG_W=IMG_H=3 -> no keypoints; complete1 at edge 8, A5 at edge 9, complete3 at edge 10.
- Reset at edge 300 (mid-emission) -> all outputs 0 at once; after release the full default sequence repeats with identical timing.
